// File: rtl/ysyx_22050612_wb_arbiter.sv
// ysyx_22050612_wb_arbiter: shares the GPR write port between the ALU and LSU result producers
// Ports: alu_*/lsu_* valid/ready/rd/wdata producer handshakes; rf_wen/rf_waddr/rf_wdata registered
// RegisterFile write port; wb_src registered source of the write (0=ALU, 1=LSU); alu_wait ALU wait count.
module ysyx_22050612_wb_arbiter #(
  parameter int XLEN     = 64,
  parameter int MAX_WAIT = 3,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [4:0]       alu_rd,
  input  logic [XLEN-1:0]  alu_wdata,
  input  logic             lsu_valid,
  output logic             lsu_ready,
  input  logic [4:0]       lsu_rd,
  input  logic [XLEN-1:0]  lsu_wdata,
  output logic             rf_wen,
  output logic [4:0]       rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             wb_src,
  output logic [CNT_W-1:0] alu_wait
);
  logic force_alu;
  logic alu_xfer;
  logic lsu_xfer;
  always_comb begin
    force_alu = alu_valid && (alu_wait == CNT_W'(MAX_WAIT));
    alu_ready = rst_n && (force_alu || (alu_valid && !lsu_valid));
    lsu_ready = rst_n && lsu_valid && !force_alu;
    alu_xfer  = alu_valid && alu_ready;
    lsu_xfer  = lsu_valid && lsu_ready;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      wb_src   <= 1'b0;
      alu_wait <= '0;
    end else begin
      rf_wen   <= alu_xfer ? (alu_rd != 5'd0) : lsu_xfer ? (lsu_rd != 5'd0) : 1'b0;
      rf_waddr <= alu_xfer ? alu_rd : lsu_xfer ? lsu_rd : rf_waddr;
      rf_wdata <= alu_xfer ? alu_wdata : lsu_xfer ? lsu_wdata : rf_wdata;
      wb_src   <= alu_xfer ? 1'b0 : lsu_xfer ? 1'b1 : wb_src;
      alu_wait <= alu_xfer ? '0
                : (alu_valid && alu_wait != CNT_W'(MAX_WAIT)) ? alu_wait + CNT_W'(1)
                : alu_wait;
    end
  end
endmodule

// File: tb/tb_ysyx_22050612_wb_arbiter.sv
// tb_ysyx_22050612_wb_arbiter: scoreboard bench for the write-back arbiter
module tb_ysyx_22050612_wb_arbiter;
  localparam int XLEN = 64;
  localparam int MAX_WAIT = 3;
  localparam int CNT_W = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic alu_valid = 1'b0;
  logic lsu_valid = 1'b0;
  logic [4:0] alu_rd = '0;
  logic [4:0] lsu_rd = '0;
  logic [XLEN-1:0] alu_wdata = '0;
  logic [XLEN-1:0] lsu_wdata = '0;
  logic alu_ready;
  logic lsu_ready;
  logic rf_wen;
  logic [4:0] rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic wb_src;
  logic [CNT_W-1:0] alu_wait;
  typedef struct packed {
    logic wen;
    logic [4:0] addr;
    logic [XLEN-1:0] data;
    logic src;
  } wr_t;
  wr_t exp_q[$];
  int m_wait = 0;
  logic [4:0] l_addr = '0;
  logic [XLEN-1:0] l_data = '0;
  logic l_src = 1'b0;
  bit a_win;
  bit l_win;
  int n_chk = 0;
  int n_err = 0;
  ysyx_22050612_wb_arbiter #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_wdata(alu_wdata),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_wdata(lsu_wdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_src(wb_src),
    .alu_wait(alu_wait)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Called just after a falling edge with inputs applied; predicts the grant
  // from the ALU's losing streak and queues the write expected after the next rising edge.
  task automatic cycle();
    wr_t e;
    #1;
    a_win = alu_valid && (m_wait == MAX_WAIT || !lsu_valid);
    l_win = lsu_valid && !a_win;
    chk("alu_ready", 64'(alu_ready), 64'(a_win));
    chk("lsu_ready", 64'(lsu_ready), 64'(l_win));
    chk("alu_wait", 64'(alu_wait), 64'(m_wait));
    if (a_win) begin
      m_wait = 0;
      l_addr = alu_rd;
      l_data = alu_wdata;
      l_src = 1'b0;
    end else begin
      if (alu_valid) m_wait++;
      if (l_win) begin
        l_addr = lsu_rd;
        l_data = lsu_wdata;
        l_src = 1'b1;
      end
    end
    e.wen = (a_win || l_win) && l_addr != 5'd0;
    e.addr = l_addr;
    e.data = l_data;
    e.src = l_src;
    exp_q.push_back(e);
    @(negedge clk);
  endtask
  always @(posedge clk) begin : monitor
    wr_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rf_wen", 64'(rf_wen), 64'(e.wen));
      chk("rf_waddr", 64'(rf_waddr), 64'(e.addr));
      chk("rf_wdata", rf_wdata, e.data);
      chk("wb_src", 64'(wb_src), 64'(e.src));
    end
  end
  initial begin
    alu_valid = 1'b1;
    alu_rd = 5'd5;
    alu_wdata = 64'h10;
    #12;
    chk("rst_alu_ready", 64'(alu_ready), 64'd0);
    chk("rst_lsu_ready", 64'(lsu_ready), 64'd0);
    chk("rst_rf_wen", 64'(rf_wen), 64'd0);
    chk("rst_alu_wait", 64'(alu_wait), 64'd0);
    chk("rst_rf_waddr", 64'(rf_waddr), 64'd0);
    chk("rst_rf_wdata", rf_wdata, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    alu_valid = 1'b0;
    cycle();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_wdata = 64'hAA;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_wdata = 64'hBB;
    cycle();
    lsu_valid = 1'b0;
    cycle();
    alu_valid = 1'b0;
    cycle();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_wdata = 64'h77;
    lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_wdata = 64'h100;
    for (int i = 0; i < 7; i++) begin
      cycle();
      if (a_win) alu_valid = 1'b0;
      if (l_win) begin
        lsu_rd = 5'(9 + i);
        lsu_wdata = 64'(i + 'h200);
      end
    end
    lsu_valid = 1'b0;
    cycle();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_wdata = 64'hFFFF;
    cycle();
    alu_valid = 1'b0;
    cycle();
    alu_rd = 5'd9;
    for (int i = 0; i < 5; i++) begin
      alu_valid = (i % 2 == 0);
      alu_wdata = 64'(i + 'h300);
      cycle();
    end
    alu_valid = 1'b0;
    for (int n = 0; n < 400; n++) begin
      cycle();
      if (a_win || !alu_valid) begin
        alu_valid = $urandom_range(0, 99) < 55;
        alu_rd = 5'($urandom_range(0, 31));
        alu_wdata = {$urandom, $urandom};
      end
      if (l_win || !lsu_valid) begin
        lsu_valid = $urandom_range(0, 99) < 60;
        lsu_rd = 5'($urandom_range(0, 31));
        lsu_wdata = {$urandom, $urandom};
      end
    end
    alu_valid = 1'b0;
    lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_wdata = 64'hC0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      lsu_rd = 5'(11 + i);
      lsu_wdata = 64'(i + 'hC1);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_rf_wen", 64'(rf_wen), 64'd0);
    chk("arst_rf_waddr", 64'(rf_waddr), 64'd0);
    chk("arst_rf_wdata", rf_wdata, 64'd0);
    chk("arst_wb_src", 64'(wb_src), 64'd0);
    chk("arst_lsu_ready", 64'(lsu_ready), 64'd0);
    chk("arst_alu_wait", 64'(alu_wait), 64'd0);
    m_wait = 0;
    l_addr = '0;
    l_data = '0;
    l_src = 1'b0;
    exp_q.delete();
    lsu_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    cycle();
    lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_wdata = 64'hD0;
    cycle();
    lsu_valid = 1'b0;
    cycle();
    @(posedge clk);
    #2;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
